// File: rtl/edge_roi_threshold.sv
// Single-pass hysteresis edge thresholding over a raster frame; ROI pixels are
// forwarded as 8'hFF/8'h00 bytes, all other pixels are consumed and dropped.
module edge_roi_threshold #(
    parameter int          WIDTH       = 720,
    parameter int          HEIGHT      = 540,
    parameter int          X_WIDTH     = 16,
    parameter int          Y_WIDTH     = 16,
    parameter int          X_START     = 100,
    parameter int          X_END       = 620,
    parameter int          Y_START     = 300,
    parameter int          Y_END       = 540,
    parameter logic [7:0]  HIGH_THRESH = 8'd100,
    parameter logic [7:0]  LOW_THRESH  = 8'd50
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output logic                       o_in_rd_en,
    input  logic                       i_in_empty,
    input  logic [7:0]                 i_in_dout,
    output logic                       o_out_wr_en,
    input  logic                       i_out_full,
    output logic [7:0]                 o_out_din,
    output logic                       o_frame_done,
    output logic [Y_WIDTH+X_WIDTH-1:0] o_edge_count,
    output logic                       o_dbg_state
);

    typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

    localparam int CW = Y_WIDTH + X_WIDTH;
    localparam int XI = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [X_WIDTH-1:0] LP_X_START = X_WIDTH'(X_START);
    localparam logic [X_WIDTH-1:0] LP_X_END   = X_WIDTH'(X_END);
    localparam logic [X_WIDTH-1:0] LP_X_LAST  = X_WIDTH'(WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] LP_Y_START = Y_WIDTH'(Y_START);
    localparam logic [Y_WIDTH-1:0] LP_Y_END   = Y_WIDTH'(Y_END);
    localparam logic [Y_WIDTH-1:0] LP_Y_LAST  = Y_WIDTH'(HEIGHT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    logic               r_left;
    logic [WIDTH-1:0]   r_linebuf;
    logic [CW-1:0]      r_acc;
    logic [CW-1:0]      r_edge_count;

    logic [XI-1:0]      w_xi;
    logic               w_in_roi;
    logic               w_strong;
    logic               w_weak;
    logic               w_above;
    logic               w_edge;
    logic               w_x_last;
    logic               w_y_last;
    logic               w_accept;
    logic               w_frame_done;

    assign w_xi     = r_x[XI-1:0];
    assign w_in_roi = (r_x >= LP_X_START) && (r_x < LP_X_END) &&
                      (r_y >= LP_Y_START) && (r_y < LP_Y_END);
    assign w_strong = (i_in_dout >= HIGH_THRESH);
    assign w_weak   = (i_in_dout >= LOW_THRESH);
    // Row 0 ignores the line buffer, so stale data from the previous frame never leaks in.
    assign w_above  = (r_y != '0) ? r_linebuf[w_xi] : 1'b0;
    assign w_edge   = w_strong | (w_weak & (r_left | w_above));
    assign w_x_last = (r_x == LP_X_LAST);
    assign w_y_last = (r_y == LP_Y_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_RUN;
        else          r_state <= w_next;
    end

    // Reset gates the handshake outputs combinationally so they drop immediately.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_RUN: begin
                w_accept = i_rst_n && !i_in_empty && (!i_out_full || !w_in_roi);
                if (w_accept && w_x_last && w_y_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_frame_done = i_rst_n;
                w_next       = S_RUN;
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_left       <= 1'b0;
            r_linebuf    <= '0;
            r_acc        <= '0;
            r_edge_count <= '0;
        end else if (r_state == S_DONE) begin
            r_edge_count <= r_acc;
            r_acc        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_left       <= 1'b0;
        end else if (w_accept) begin
            r_linebuf[w_xi] <= w_edge;
            r_acc           <= r_acc + CW'(w_in_roi && w_edge);
            if (w_x_last) begin
                r_x    <= '0;
                r_y    <= r_y + 1'b1;
                r_left <= 1'b0;
            end else begin
                r_x    <= r_x + 1'b1;
                r_left <= w_edge;
            end
        end
    end

    assign o_in_rd_en   = w_accept;
    assign o_out_wr_en  = w_accept && w_in_roi;
    assign o_out_din    = (w_accept && w_in_roi && w_edge) ? 8'hFF : 8'h00;
    assign o_frame_done = w_frame_done;
    assign o_edge_count = r_edge_count;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_edge_roi_threshold.sv
// Bench for edge_roi_threshold on an 8x4 frame with ROI x 2..5, y 1..3.
module tb_edge_roi_threshold;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int NPX = W * H;
    localparam int NRO = 12;

    logic        clk;
    logic        rst_n;
    logic        in_rd_en;
    logic        in_empty;
    logic [7:0]  in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;
    logic [31:0] edge_count;
    logic        dbg_state;

    logic [7:0]  exp_q[$];
    logic [7:0]  pix [NPX];
    logic [7:0]  got [NRO];
    logic [7:0]  ref2 [NRO];
    int          n_vec = 0;
    int          n_err = 0;

    edge_roi_threshold #(
        .WIDTH(W), .HEIGHT(H), .X_WIDTH(16), .Y_WIDTH(16),
        .X_START(2), .X_END(6), .Y_START(1), .Y_END(4),
        .HIGH_THRESH(8'd100), .LOW_THRESH(8'd50)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_in_rd_en(in_rd_en), .i_in_empty(in_empty), .i_in_dout(in_dout),
        .o_out_wr_en(out_wr_en), .i_out_full(out_full), .o_out_din(out_din),
        .o_frame_done(frame_done), .o_edge_count(edge_count),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: hysteresis over the full frame, ROI bytes pushed to the scoreboard
    task automatic load_model(output int cnt);
        logic ef [NPX];
        logic s, wk, ab, lf, e, roi;
        cnt = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                s   = (pix[y*W+x] >= 8'd100);
                wk  = (pix[y*W+x] >= 8'd50);
                ab  = (y > 0) ? ef[(y-1)*W+x] : 1'b0;
                lf  = (x > 0) ? ef[y*W+x-1] : 1'b0;
                e   = s | (wk & (ab | lf));
                ef[y*W+x] = e;
                roi = (x >= 2) && (x < 6) && (y >= 1) && (y < 4);
                if (roi) begin
                    exp_q.push_back(e ? 8'hFF : 8'h00);
                    if (e) cnt++;
                end
            end
        end
    endtask

    // driver + scoreboard for one frame
    task automatic run_frame(input int stall_at, input int stall_len, input bit rand_empty,
                             input bit keep_going, input int prev_cnt,
                             output int cycles, output int stall_pops);
        int pops = 0;
        int cyc = 0;
        int n_out = 0;
        int exp_cnt;
        logic full, empty;
        logic [7:0] e;
        stall_pops = 0;
        load_model(exp_cnt);
        while (pops < NPX && cyc < 500) begin
            full  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            empty = rand_empty ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            in_empty = empty;
            out_full = full;
            in_dout  = pix[pops];
            #1;
            if (cyc == 0 && prev_cnt >= 0) begin
                n_vec++;
                if (edge_count !== 32'(prev_cnt)) begin
                    n_err++;
                    $display("FAIL prev_edge_count: got %0d want %0d", edge_count, prev_cnt);
                end
            end
            n_vec++;
            if (frame_done !== 1'b0 || (empty && in_rd_en) || (full && out_wr_en) ||
                (!out_wr_en && out_din !== 8'h00)) begin
                n_err++;
                $display("FAIL handshake: cyc %0d done=%b rd=%b wr=%b din=%h empty=%b full=%b",
                         cyc, frame_done, in_rd_en, out_wr_en, out_din, empty, full);
            end
            if (out_wr_en === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_write: got %h want none", out_din);
                end else begin
                    e = exp_q.pop_front();
                    if (out_din !== e) begin
                        n_err++;
                        $display("FAIL out_din[%0d]: got %h want %h", n_out, out_din, e);
                    end
                end
                if (n_out < NRO) got[n_out] = out_din;
                n_out++;
            end
            if (in_rd_en === 1'b1) begin
                pops++;
                if (full) stall_pops++;
            end
            cyc++;
        end
        cycles = cyc;
        n_vec++;
        if (pops < NPX) begin
            n_err++;
            $display("FAIL frame_timeout: got %0d pops want %0d", pops, NPX);
        end
        n_vec++;
        if (n_out != NRO || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL write_count: got %0d want %0d", n_out, NRO);
        end
        exp_q.delete();
        // dead cycle: frame_done and no FIFO activity even with data available
        @(negedge clk);
        in_empty = keep_going ? 1'b0 : 1'b1;
        out_full = 1'b0;
        #1;
        n_vec++;
        if (frame_done !== 1'b1 || in_rd_en !== 1'b0 || out_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL done_cycle: got done=%b rd=%b wr=%b want 1 0 0", frame_done, in_rd_en, out_wr_en);
        end
        if (!keep_going) begin
            @(negedge clk);
            in_empty = 1'b1;
            #1;
            n_vec++;
            if (edge_count !== 32'(exp_cnt) || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL edge_count: got %0d (done=%b) want %0d", edge_count, frame_done, exp_cnt);
            end
        end
    endtask

    task automatic clear_pix();
        for (int i = 0; i < NPX; i++) pix[i] = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0 || frame_done !== 1'b0 ||
            edge_count !== 32'd0 || out_din !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: rd=%b wr=%b done=%b cnt=%0d din=%h want all zero",
                     in_rd_en, out_wr_en, frame_done, edge_count, out_din);
        end
        @(negedge clk);
        in_empty = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int c, sp;
        clear_pix();
        run_frame(1000, 0, 1'b0, 1'b0, -1, c, sp);
        n_vec++;
        if (c != NPX) begin
            n_err++;
            $display("FAIL zero_frame_cycles: got %0d want %0d", c, NPX);
        end
        for (int i = 0; i < NRO; i++) begin
            n_vec++;
            if (got[i] !== 8'h00) begin
                n_err++;
                $display("FAIL zero_byte[%0d]: got %h want 00", i, got[i]);
            end
        end
    endtask

    task automatic test_single_strong();
        int c, sp;
        clear_pix();
        pix[2*W+3] = 8'd200;
        run_frame(1000, 0, 1'b0, 1'b0, -1, c, sp);
        for (int i = 0; i < NRO; i++) begin
            ref2[i] = got[i];
            n_vec++;
            if (got[i] !== ((i == 5) ? 8'hFF : 8'h00)) begin
                n_err++;
                $display("FAIL single_byte[%0d]: got %h want %h", i, got[i], (i == 5) ? 8'hFF : 8'h00);
            end
        end
        n_vec++;
        if (edge_count !== 32'd1) begin
            n_err++;
            $display("FAIL single_count: got %0d want 1", edge_count);
        end
    endtask

    task automatic test_hysteresis();
        int c, sp;
        logic [7:0] want [NRO];
        want = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                 8'h00, 8'hFF, 8'h00, 8'h00};
        clear_pix();
        pix[2*W+2] = 8'd120; pix[2*W+3] = 8'd60; pix[2*W+4] = 8'd60; pix[2*W+5] = 8'd40;
        pix[3*W+3] = 8'd60;  pix[3*W+4] = 8'd0;  pix[3*W+5] = 8'd60;
        run_frame(1000, 0, 1'b0, 1'b0, -1, c, sp);
        for (int i = 0; i < NRO; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin
                n_err++;
                $display("FAIL hyst_byte[%0d]: got %h want %h", i, got[i], want[i]);
            end
        end
        n_vec++;
        if (edge_count !== 32'd4) begin
            n_err++;
            $display("FAIL hyst_count: got %0d want 4", edge_count);
        end
    endtask

    task automatic test_backpressure();
        int c, sp;
        clear_pix();
        pix[2*W+3] = 8'd200;
        // full over cycles 9..13: x=1 of row 1 drains, x=2 then waits four cycles
        run_frame(9, 5, 1'b0, 1'b0, -1, c, sp);
        n_vec++;
        if (c != NPX + 4 || sp != 1) begin
            n_err++;
            $display("FAIL bp_timing: got %0d cycles %0d stall pops want %0d and 1", c, sp, NPX + 4);
        end
        for (int i = 0; i < NRO; i++) begin
            n_vec++;
            if (got[i] !== ref2[i]) begin
                n_err++;
                $display("FAIL bp_byte[%0d]: got %h want %h", i, got[i], ref2[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int c, sp;
        clear_pix();
        for (int i = 0; i < NPX; i++) pix[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_empty = 1'b0; out_full = 1'b0; in_dout = pix[k];
            #1;
            if (in_rd_en === 1'b1) k++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0 || frame_done !== 1'b0 || edge_count !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: rd=%b wr=%b done=%b cnt=%0d want 0 0 0 0",
                     in_rd_en, out_wr_en, frame_done, edge_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_empty = 1'b1;
        clear_pix();
        pix[2*W+3] = 8'd200;
        run_frame(1000, 0, 1'b0, 1'b0, -1, c, sp);
        for (int i = 0; i < NRO; i++) begin
            n_vec++;
            if (got[i] !== ref2[i]) begin
                n_err++;
                $display("FAIL rst_byte[%0d]: got %h want %h", i, got[i], ref2[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, sp;
        logic [7:0] first [NRO];
        clear_pix();
        pix[1*W+2] = 8'd150; pix[1*W+3] = 8'd70; pix[2*W+3] = 8'd55; pix[3*W+6] = 8'd99;
        pix[3*W+7] = 8'd101; pix[3*W+5] = 8'd80;
        run_frame(1000, 0, 1'b0, 1'b1, -1, c1, sp);
        for (int i = 0; i < NRO; i++) first[i] = got[i];
        run_frame(1000, 0, 1'b0, 1'b0, 3, c2, sp);
        n_vec++;
        if (c1 != NPX || c2 != NPX) begin
            n_err++;
            $display("FAIL b2b_cycles: got %0d and %0d want %0d each", c1, c2, NPX);
        end
        for (int i = 0; i < NRO; i++) begin
            n_vec++;
            if (got[i] !== first[i]) begin
                n_err++;
                $display("FAIL b2b_byte[%0d]: got %h want %h", i, got[i], first[i]);
            end
        end
    endtask

    task automatic test_random();
        int c, sp;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPX; i++) pix[i] = 8'($urandom_range(0, 140));
            run_frame($urandom_range(3, 20), $urandom_range(1, 6), 1'b1, 1'b0, -1, c, sp);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_strong();
        test_hysteresis();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_roi_threshold.md
# edge_roi_threshold

Streaming stage directly upstream of `hough_transform`. It pops raster-ordered 8-bit gradient-magnitude pixels for a full WIDTH×HEIGHT frame from an input FIFO and applies single-pass hysteresis thresholding. For each pixel inside the Hough ROI it pushes one byte into the FIFO that feeds `hough_transform`: 8'hFF for an edge pixel, 8'h00 for a non-edge pixel. Pixels outside the ROI are consumed and discarded, so the downstream x/y raster counters stay aligned.

## Interface
- WIDTH, 720, frame width in pixels
- HEIGHT, 540, frame height in pixels
- X_WIDTH, 16, x counter width
- Y_WIDTH, 16, y counter width
- X_START, 100, first ROI column (inclusive)
- X_END, 620, ROI column end (exclusive)
- Y_START, 300, first ROI row (inclusive)
- Y_END, 540, ROI row end (exclusive)
- HIGH_THRESH, 100, strong-edge threshold (8-bit)
- LOW_THRESH, 50, weak-edge threshold (8-bit, ≤ HIGH_THRESH)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_rd_en  out  1  pop input FIFO (first-word-fall-through)
- in_empty  in  1  input FIFO empty
- in_dout  in  8  gradient magnitude of current pixel
- out_wr_en  out  1  push output FIFO
- out_full  in  1  output FIFO full
- out_din  out  8  8'hFF edge / 8'h00 non-edge
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is consumed
- edge_count  out  Y_WIDTH+X_WIDTH  number of ROI edge pixels in the last completed frame

## Operation
- State machine RUN / DONE. Reset state: RUN with x=0, y=0, left=0, line buffer all 0, edge_count=0.
- in_roi = (X_START ≤ x < X_END) && (Y_START ≤ y < Y_END).
- strong = in_dout ≥ HIGH_THRESH. weak = in_dout ≥ LOW_THRESH.
- above = linebuf[x] when y>0, otherwise 0. left = edge flag of (x-1,y) when x>0, otherwise 0.
- edge = strong | (weak & (left | above)). Hysteresis is computed over the whole frame, not only the ROI.
- RUN, pixel accepted: in_rd_en = !in_empty && (!out_full || !in_roi).
  - If in_roi: out_wr_en=1 and out_din = edge ? 8'hFF : 8'h00.
  - linebuf[x] ← edge; left ← edge.
  - x increments. On x==WIDTH-1: x←0, y increments, left←0.
  - On x==WIDTH-1 && y==HEIGHT-1: go to DONE.
  - Frame edge accumulator increments when in_roi && edge (width Y_WIDTH+X_WIDTH, cannot overflow).
- RUN, no accept: no state change, in_rd_en=0, out_wr_en=0.
- DONE, one cycle:
  - frame_done=1; edge_count ← accumulator; accumulator←0.
  - x←0, y←0, left←0. No FIFO activity.
  - Return to RUN.
  - Line buffer is not cleared; the y==0 masking makes stale contents irrelevant.

## Timing
- Zero-latency datapath: out_wr_en/out_din are combinational from in_dout in the same cycle as in_rd_en. Counters and flags update on the next rising edge.
- Throughput: one pixel per cycle when not stalled. One dead cycle (DONE) between frames.
- in_rd_en, out_wr_en and frame_done are 0 during reset and in DONE (except frame_done=1 in DONE). out_din=8'h00 whenever out_wr_en=0.
- Backpressure: with out_full=1, ROI pixels stall. Non-ROI pixels continue to drain.
- An empty input stalls regardless of out_full.
- Reset deasserted mid-frame: the block restarts at (0,0) for the next pixel popped. The upstream producer is responsible for frame realignment.
- edge_count holds its value until the next DONE.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=4, ROI x 2..5, y 1..3 (X_END=6, Y_END=4), HIGH=100, LOW=50.
- All-zero frame -> exactly 12 writes of 8'h00; frame_done pulses once, one cycle after the 32nd pop; edge_count=0.
- Single 200 at (3,2), all else 0 -> write #5 (0-based) is 8'hFF, all other writes 8'h00; edge_count=1.
- Hysteresis:
  - Row 2, x=2..5 = 120,60,60,40 -> FF,FF,FF,00.
  - (3,3)=60 -> FF (above is edge).
  - (5,3)=60, with (4,3)=0 -> 00.
  - edge_count=4.
- Backpressure: hold out_full=1 for 5 cycles during row 1 -> no in_rd_en for ROI pixels, out-of-ROI pixels still popped; output byte sequence identical to the unstalled run.
- Reset low for 2 cycles mid-frame -> in_rd_en/out_wr_en/frame_done drop to 0 asynchronously; the following full frame reproduces the scenario-2 output exactly.
- Two back-to-back frames with in_empty=0 -> frame_done pulses twice with exactly one cycle of no pops between frames; both frames produce identical output bytes.
